// File: rtl/cell_sort_reader.sv
// Read-out end of the systolic cell sorter: settles, snapshots and streams the array best-first.
// Optional stall counter output is enabled by defining CELL_SORT_READER_STALL_CNT_EN.
module cell_sort_reader #(
   parameter int SORTB   = 8,
   parameter int METAB   = 32,
   parameter int DEPTH   = 8,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 64,
   localparam int IW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1),
   localparam int SW = $clog2(SETTLE + 1),
   localparam int TW = $clog2(TIMEOUT + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dav_i,
   input  logic                        start_i,
   input  logic [DEPTH-1:0][SORTB-1:0] data_i,
   input  logic [DEPTH-1:0][METAB-1:0] metadata_i,
   input  logic [DEPTH-1:0]            updating_i,
   output logic                        clear_o,
   output logic [SORTB-1:0]            data_o,
   output logic [METAB-1:0]            metadata_o,
   output logic [IW-1:0]               index_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        last_o,
   output logic                        busy_o,
   output logic                        dropped_o,
   output logic                        err_o
`ifdef CELL_SORT_READER_STALL_CNT_EN
   ,
   output logic [15:0]                 stall_cnt_o
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SNAP, ST_STREAM} state_t;

   state_t          state;
   logic [CW-1:0]   count, count_next, n;
   logic [SW-1:0]   settle_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [IW-1:0]   next_idx;
   logic [SORTB-1:0] shadow_data [DEPTH];
   logic [METAB-1:0] shadow_meta [DEPTH];

   assign busy_o    = (state != ST_IDLE);
   assign dropped_o = start_i && (state != ST_IDLE);
   assign next_idx  = index_o + IW'(1);

   always_comb begin
      count_next = count;
      if (dav_i && count != CW'(DEPTH))
         count_next = count + CW'(1);
   end

   // NOTE: the snapshot is plain storage gated by the SNAP state; it needs no reset
   // because nothing reads it before a SNAP has written it.
   always_ff @(posedge clk) begin
      if (state == ST_SNAP) begin
         for (int k = 0; k < DEPTH; k++) begin
            shadow_data[k] <= data_i[DEPTH-1-k];
            shadow_meta[k] <= metadata_i[DEPTH-1-k];
         end
      end
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // branch below sees the values from the start of the cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         n          <= '0;
         settle_cnt <= '0;
         tmo_cnt    <= '0;
         clear_o    <= 1'b0;
         data_o     <= '0;
         metadata_o <= '0;
         index_o    <= '0;
         valid_o    <= 1'b0;
         last_o     <= 1'b0;
         err_o      <= 1'b0;
`ifdef CELL_SORT_READER_STALL_CNT_EN
         stall_cnt_o <= '0;
`endif
      end else begin
         clear_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               count <= count_next;
               if (start_i) begin
                  n <= count_next;
                  if (count_next != '0) begin
                     state      <= ST_SETTLE;
                     settle_cnt <= '0;
                     tmo_cnt    <= '0;
                  end else begin
                     // Empty frame: one terminating beat carrying zeros.
                     state      <= ST_STREAM;
                     valid_o    <= 1'b1;
                     last_o     <= 1'b1;
                     data_o     <= '0;
                     metadata_o <= '0;
                     index_o    <= '0;
                  end
               end
            end
            ST_SETTLE: begin
               if (dav_i)
                  err_o <= 1'b1;
               settle_cnt <= (updating_i == '0) ? settle_cnt + SW'(1) : '0;
               tmo_cnt    <= tmo_cnt + TW'(1);
               if (updating_i == '0 && settle_cnt == SW'(SETTLE - 1)) begin
                  state   <= ST_SNAP;
                  clear_o <= 1'b1;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  state   <= ST_SNAP;
                  clear_o <= 1'b1;
                  err_o   <= 1'b1;
               end
            end
            ST_SNAP: begin
               // First beat comes straight from the array; the snapshot lands this same edge.
               count      <= '0;
               state      <= ST_STREAM;
               valid_o    <= 1'b1;
               data_o     <= data_i[DEPTH-1];
               metadata_o <= metadata_i[DEPTH-1];
               index_o    <= '0;
               last_o     <= (n == CW'(1));
            end
            ST_STREAM: begin
               count <= count_next;
               if (valid_o && ready_i) begin
                  if (last_o) begin
                     state      <= ST_IDLE;
                     valid_o    <= 1'b0;
                     last_o     <= 1'b0;
                     data_o     <= '0;
                     metadata_o <= '0;
                     index_o    <= '0;
                  end else begin
                     index_o    <= next_idx;
                     data_o     <= shadow_data[next_idx];
                     metadata_o <= shadow_meta[next_idx];
                     last_o     <= (CW'(index_o) + CW'(2) == n);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
`ifdef CELL_SORT_READER_STALL_CNT_EN
         if (state == ST_SNAP)
            stall_cnt_o <= '0;
         else if (valid_o && !ready_i && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
`endif
      end
   end

endmodule
